// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the 16x2 character display controller.
//   state_t      : controller state (IDLE waits for a byte, UPDATE writes the rows)
//   SPACE/BS/FF  : ASCII space, backspace and form-feed codes
//   ROW2_PREFIX  : 13-character prefix of the status line
//   ROW1_RESET   : blank row image
//   ROW2_RESET   : status line shown after reset
//   is_printable : true for bytes 0x20..0x7E
package display_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    localparam logic [7:0]   SPACE       = 8'h20;
    localparam logic [7:0]   BS          = 8'h08;
    localparam logic [7:0]   FF          = 8'h0C;
    localparam logic [7:0]   ASCII_ZERO  = 8'h30;

    localparam logic [103:0] ROW2_PREFIX = "LAST BYTE: 0x";
    localparam logic [127:0] ROW1_RESET  = {16{SPACE}};
    localparam logic [127:0] ROW2_RESET  = {ROW2_PREFIX, ASCII_ZERO, ASCII_ZERO, SPACE};

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/display_fsm_hex_to_ascii.sv
// hex_to_ascii: converts one 4-bit nibble to its uppercase ASCII hex digit.
//   i_nibble : value 0..15
//   o_ascii  : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module hex_to_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // Digits map onto '0'; letters are offset so that 10 lands on 'A' (0x37 + 10 = 0x41).
    always_comb begin
        o_ascii = 8'h30;
        if (i_nibble < 4'd10) begin
            o_ascii = 8'h30 + {4'h0, i_nibble};
        end else begin
            o_ascii = 8'h37 + {4'h0, i_nibble};
        end
    end

endmodule

// File: rtl/display_fsm.sv
// display_fsm: character display controller for a 16x2 LCD.
// Accepts one byte per rising edge of ready (only while idle) and, one cycle
// later, updates two registered 16-character row images.
//   clk   : system clock, all state changes on the rising edge
//   nRst  : synchronous active-high reset
//   ready : byte-valid level; only its rising edge is acted on
//   msg   : received byte, sampled on the accepted ready edge
//   row1  : scrolling text line, [127:120] leftmost column
//   row2  : status line "LAST BYTE: 0xHH "
module display_fsm
    import display_pkg::*;
(
    input  logic         clk,
    input  logic         nRst,
    input  logic         ready,
    input  logic [7:0]   msg,
    output logic [127:0] row1,
    output logic [127:0] row2
);

    state_t       r_state;
    state_t       w_next_state;
    logic         r_ready_q;
    logic [7:0]   r_byte_q;
    logic [127:0] r_row1;
    logic [127:0] r_row2;
    logic [127:0] w_row1_next;
    logic         w_accept;
    logic [7:0]   w_hex_hi;
    logic [7:0]   w_hex_lo;

    assign row1 = r_row1;
    assign row2 = r_row2;

    hex_to_ascii u_hex_hi (
        .i_nibble (r_byte_q[7:4]),
        .o_ascii  (w_hex_hi)
    );

    hex_to_ascii u_hex_lo (
        .i_nibble (r_byte_q[3:0]),
        .o_ascii  (w_hex_lo)
    );

    // Next-state logic: a rising ready edge is only honoured while idle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (ready && !r_ready_q) begin
                    w_accept     = 1'b1;
                    w_next_state = UPDATE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            UPDATE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Row-1 edit for the latched byte; unknown control codes leave the row alone.
    always_comb begin
        w_row1_next = r_row1;
        if (is_printable(r_byte_q)) begin
            w_row1_next = {r_row1[119:0], r_byte_q};
        end else if (r_byte_q == BS) begin
            w_row1_next = {SPACE, r_row1[127:8]};
        end else if (r_byte_q == FF) begin
            w_row1_next = ROW1_RESET;
        end else begin
            w_row1_next = r_row1;
        end
    end

    // State register and ready edge-detect history (history updates in every state).
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_state   <= IDLE;
            r_ready_q <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ready_q <= ready;
        end
    end

    // Byte latch: msg only needs to be valid on the accepted edge.
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_byte_q <= 8'h00;
        end else if (w_accept) begin
            r_byte_q <= msg;
        end else begin
            r_byte_q <= r_byte_q;
        end
    end

    // Row registers: written only in the UPDATE cycle, reset wins and drops a pending byte.
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_row1 <= ROW1_RESET;
            r_row2 <= ROW2_RESET;
        end else if (r_state == UPDATE) begin
            r_row1 <= w_row1_next;
            r_row2 <= {ROW2_PREFIX, w_hex_hi, w_hex_lo, SPACE};
        end else begin
            r_row1 <= r_row1;
            r_row2 <= r_row2;
        end
    end

endmodule

// File: tb/tb_display_fsm.sv
// tb_display_fsm: scoreboard bench for display_fsm.
// The stimulus side keeps a character-array model of the display; every accepted
// byte pushes the expected row images and the cycle they must appear. A monitor
// compares the rows on every falling edge, against the last expected images
// (held) or against the entry that falls due that cycle.
module tb_display_fsm;

    logic         clk = 1'b0;
    logic         nRst;
    logic         ready;
    logic [7:0]   msg;
    logic [127:0] row1;
    logic [127:0] row2;

    always #5 clk = ~clk;

    display_fsm dut (
        .clk   (clk),
        .nRst  (nRst),
        .ready (ready),
        .msg   (msg),
        .row1  (row1),
        .row2  (row2)
    );

    typedef struct {
        int unsigned  due;
        logic [127:0] r1;
        logic [127:0] r2;
    } exp_t;

    exp_t         q[$];
    int unsigned  cyc = 0;
    logic         rst_seen = 1'b0;
    logic         chk_en = 1'b0;
    int           total = 0;
    int           bad = 0;
    logic [127:0] cur_r1;
    logic [127:0] cur_r2;
    logic [127:0] blank_row;

    // Reference model: row 1 as 16 characters, index 0 = leftmost column.
    byte unsigned m_row1 [16];
    byte unsigned m_last;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_row1();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = m_row1[i];
        return v;
    endfunction

    function automatic logic [127:0] pack_row2();
        string        pre;
        string        hex;
        string        s;
        logic [127:0] v;
        pre = "LAST BYTE: 0x";
        hex = "0123456789ABCDEF";
        s = {pre, hex.substr(m_last / 16, m_last / 16), hex.substr(m_last % 16, m_last % 16), " "};
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_row1[i] = 8'h20;
        m_last = 8'h00;
    endfunction

    function automatic void model_apply(input byte unsigned b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            for (int i = 0; i < 15; i++) m_row1[i] = m_row1[i + 1];
            m_row1[15] = b;
        end else if (b == 8'h08) begin
            for (int i = 15; i > 0; i--) m_row1[i] = m_row1[i - 1];
            m_row1[0] = 8'h20;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 16; i++) m_row1[i] = 8'h20;
        end
        m_last = b;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= nRst;
    end

    // Monitor: reset edge restores the blank images; due entries replace the held images.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            cur_r1 = {16{8'h20}};
            cur_r2 = {"LAST BYTE: 0x", 8'h30, 8'h30, 8'h20};
            q.delete();
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            cur_r1 = e.r1;
            cur_r2 = e.r2;
        end
        if (chk_en) begin
            check("row1", row1, cur_r1);
            check("row2", row2, cur_r2);
        end
    end

    // One byte: ready high for hi cycles (msg scrambled after the rise), low for lo cycles.
    task automatic send(input byte unsigned b, input int hi, input int lo);
        exp_t e;
        @(negedge clk);
        msg   = b;
        ready = 1'b1;
        model_apply(b);
        e.due = cyc + 2;
        e.r1  = pack_row1();
        e.r2  = pack_row2();
        q.push_back(e);
        repeat (hi - 1) begin
            @(negedge clk);
            msg = 8'($urandom);
        end
        @(negedge clk);
        ready = 1'b0;
        msg   = 8'($urandom);
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst  = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries pending, required 0", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] hang;
        logic [23:0] han;
        int          r;
        byte unsigned b;
        hang      = "HANG";
        han       = "HAN";
        blank_row = {16{8'h20}};
        nRst  = 1'b1;
        ready = 1'b0;
        msg   = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        nRst = 1'b0;
        chk_en = 1'b1;
        // Idle after reset: rows must hold.
        repeat (5) @(negedge clk);

        // Non-printable byte with ready held for 5 cycles: exactly one update.
        send(8'h05, 5, 2);
        drain();
        check("row1_after_05", row1, blank_row);
        check("row2_after_05", row2, {"LAST BYTE: 0x05", 8'h20});

        // Printable stream at the fastest legal rate.
        do_reset();
        send("H", 1, 1); send("A", 1, 1); send("N", 1, 1); send("G", 1, 1);
        drain();
        check("row1_hang", row1, {{12{8'h20}}, hang});
        check("row2_hang", row2, {"LAST BYTE: 0x47", 8'h20});
        send(8'h08, 1, 1);
        drain();
        check("row1_backspace", row1, {{13{8'h20}}, han});
        send(8'h0C, 1, 1);
        drain();
        check("row1_clear", row1, blank_row);
        check("row2_clear", row2, {"LAST BYTE: 0x0C", 8'h20});

        // Wrap: 17 characters, the first scrolls out.
        do_reset();
        for (int i = 0; i < 17; i++) send(8'h41 + 8'(i), 1, 1);
        drain();
        check("row1_wrap", row1, "BCDEFGHIJKLMNOPQ");

        // Reset landing in the UPDATE cycle discards the pending byte.
        @(negedge clk);
        msg   = "Z";
        ready = 1'b1;
        @(negedge clk);
        nRst  = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        nRst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("row1_rst_in_update", row1, blank_row);
        check("row2_rst_in_update", row2, {"LAST BYTE: 0x00", 8'h20});

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      b = 8'($urandom_range(32, 126));
            else if (r == 6) b = 8'h08;
            else if (r == 7) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            send(b, $urandom_range(1, 3), $urandom_range(1, 3));
        end
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
